// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner with frame debounce, key events and a 16-bit digit shift register.
// Optional auto-repeat of a held key is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_scanner #(
    parameter int CLK_HZ          = 50_000_000,
    parameter int SCAN_HZ         = 1000,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int REPEAT_DELAY    = 250,
    parameter int REPEAT_PERIOD   = 50
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [3:0]  i_Row,
    input  logic        i_Clear,
    output logic [3:0]  o_Col,
    output logic [3:0]  o_Key,
    output logic        o_KeyValid,
    output logic        o_KeyStrobe,
    output logic [15:0] o_Digit
);
    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DB_W     = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [4:0] NONE = 5'b0_0000;

    typedef enum logic {S_SCAN, S_EVAL} state_t;
    state_t r_state, w_state_nxt;

    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_col;
    logic [1:0]       r_nkeys;
    logic [3:0]       r_kcode;
    logic [4:0]       r_prev, r_deb;
    logic [DB_W-1:0]  r_stable;
    logic [3:0]       r_key;
    logic             r_valid, r_strobe;
    logic [15:0]      r_digit;

    logic             w_tick, w_eval;
    logic [2:0]       w_nlow, w_sum;
    logic [1:0]       w_base, w_row, w_nkeys_nxt;
    logic [3:0]       w_kcode_nxt;
    logic [4:0]       w_res, w_deb_nxt;
    logic [DB_W-1:0]  w_stable_nxt;
    logic             w_change, w_press, w_repeat;

    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        code = 4'h0;
        case ({row, col})
            4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
            4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
            4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
            4'hC: code = 4'h0;  4'hD: code = 4'hF;  4'hE: code = 4'hE;  default: code = 4'hD;
        endcase
        return code;
    endfunction

    assign w_tick = (r_div == DIV_W'(SCAN_DIV - 1));
    assign o_Col  = ~(4'b0001 << r_col);

    // Column 0 starts a fresh frame; key count saturates at 2 (= ambiguous)
    assign w_nlow = 3'(!i_Row[0]) + 3'(!i_Row[1]) + 3'(!i_Row[2]) + 3'(!i_Row[3]);
    assign w_base = (r_col == 2'd0) ? 2'd0 : r_nkeys;
    assign w_sum  = {1'b0, w_base} + w_nlow;
    assign w_nkeys_nxt = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];

    always_comb begin
        w_row = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!i_Row[r]) w_row = 2'(r);
        end
    end

    assign w_kcode_nxt = (w_nlow == 3'd1 && w_base == 2'd0) ? key_code(w_row, r_col) : r_kcode;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div   <= '0;
            r_col   <= 2'd0;
            r_nkeys <= 2'd0;
            r_kcode <= 4'h0;
        end else if (w_tick) begin
            r_div   <= '0;
            r_col   <= r_col + 2'd1;
            r_nkeys <= w_nkeys_nxt;
            r_kcode <= w_kcode_nxt;
        end else begin
            r_div   <= r_div + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_SCAN;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_eval      = 1'b0;
        unique case (r_state)
            S_SCAN: if (w_tick && r_col == 2'd3) w_state_nxt = S_EVAL;
            S_EVAL: begin
                w_eval      = 1'b1;
                w_state_nxt = S_SCAN;
            end
        endcase
    end

    assign w_res = (r_nkeys == 2'd1) ? {1'b1, r_kcode} : NONE;

    always_comb begin
        w_stable_nxt = DB_W'(1);
        if (w_res == r_prev) begin
            if (r_stable == DB_W'(DEBOUNCE_FRAMES)) w_stable_nxt = r_stable;
            else                                    w_stable_nxt = r_stable + 1'b1;
        end
        w_deb_nxt = (w_stable_nxt == DB_W'(DEBOUNCE_FRAMES)) ? w_res : r_deb;
        w_change  = (w_deb_nxt != r_deb);
        w_press   = w_change && w_deb_nxt[4];
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RP_W   = $clog2(RP_MAX + 1);
    logic [RP_W-1:0] r_rep, w_rep_inc;
    logic            r_first;

    assign w_rep_inc = r_rep + 1'b1;
    assign w_repeat  = w_eval && !w_change && r_deb[4] &&
                       (r_first ? (w_rep_inc == RP_W'(REPEAT_DELAY))
                                : (w_rep_inc == RP_W'(REPEAT_PERIOD)));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rep   <= '0;
            r_first <= 1'b0;
        end else if (w_eval) begin
            if (w_change) begin
                r_rep   <= '0;
                r_first <= 1'b1;
            end else if (w_repeat) begin
                r_rep   <= '0;
                r_first <= 1'b0;
            end else if (r_deb[4]) begin
                r_rep   <= w_rep_inc;
            end
        end
    end
`else
    logic w_unused_rep;
    assign w_unused_rep = (REPEAT_DELAY > REPEAT_PERIOD);
    assign w_repeat     = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev   <= NONE;
            r_stable <= '0;
            r_deb    <= NONE;
            r_key    <= 4'h0;
            r_valid  <= 1'b0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (w_eval) begin
                r_prev   <= w_res;
                r_stable <= w_stable_nxt;
                r_deb    <= w_deb_nxt;
                if (w_change) r_valid <= w_deb_nxt[4];
                if (w_press)  r_key   <= w_deb_nxt[3:0];
                r_strobe <= w_press | w_repeat;
            end
        end
    end

    // Shift happens during the strobe cycle so a coincident clear sees the new key
    always_ff @(posedge i_clk) begin
        if (i_rst)            r_digit <= 16'h0000;
        else if (i_Clear)     r_digit <= r_strobe ? {12'h000, r_key} : 16'h0000;
        else if (r_strobe)    r_digit <= {r_digit[11:0], r_key};
    end

    assign o_Key       = r_key;
    assign o_KeyValid  = r_valid;
    assign o_KeyStrobe = r_strobe;
    assign o_Digit     = r_digit;
endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: 4 cycles/column, 16 cycles/frame, 2-frame debounce.
// Define KEYPAD_AUTOREPEAT_EN to run the auto-repeat scenario instead of the single-strobe ones.
module tb_keypad_scanner;
    localparam int FR = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row;
    logic        clr;
    logic [3:0]  col;
    logic [3:0]  key;
    logic        kvalid;
    logic        kstrobe;
    logic [15:0] digit;

    keypad_scanner #(
        .CLK_HZ(400), .SCAN_HZ(100), .DEBOUNCE_FRAMES(2),
        .REPEAT_DELAY(3), .REPEAT_PERIOD(2)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_Row(row), .i_Clear(clr),
        .o_Col(col), .o_Key(key), .o_KeyValid(kvalid),
        .o_KeyStrobe(kstrobe), .o_Digit(digit)
    );

    always #5 clk = ~clk;

    logic [3:0] pressed [4];

    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) row[r] = ~|(pressed[r] & ~col);
    end

    typedef struct packed {
        logic [3:0]  k;
        logic [15:0] d;
    } exp_t;

    exp_t        q[$];
    logic [15:0] exp_dig;
    int          total = 0;
    int          bad = 0;
    bit          pend = 0;
    logic [15:0] pend_dig;
    int          cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            pend = 0;
        end else begin
            if (pend) begin
                pend = 0;
                chk("digit", digit, pend_dig);
            end
            if (kstrobe) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL strobe: got unexpected key %h want none", key);
                end else begin
                    e = q.pop_front();
                    chk("key", {12'h0, key}, {12'h0, e.k});
                    chk("valid_at_strobe", {15'h0, kvalid}, 16'h1);
                    pend     = 1;
                    pend_dig = e.d;
                end
            end
        end
    end

    function automatic logic [3:0] pos(input logic [3:0] k);
        logic [3:0] p;
        case (k)
            4'h1: p = 4'h0; 4'h2: p = 4'h1; 4'h3: p = 4'h2; 4'hA: p = 4'h3;
            4'h4: p = 4'h4; 4'h5: p = 4'h5; 4'h6: p = 4'h6; 4'hB: p = 4'h7;
            4'h7: p = 4'h8; 4'h8: p = 4'h9; 4'h9: p = 4'hA; 4'hC: p = 4'hB;
            4'h0: p = 4'hC; 4'hF: p = 4'hD; 4'hE: p = 4'hE; default: p = 4'hF;
        endcase
        return p;
    endfunction

    task automatic press(input logic [3:0] k);
        logic [3:0] p;
        p = pos(k);
        pressed[p[3:2]][p[1:0]] = 1'b1;
    endtask

    task automatic unpress(input logic [3:0] k);
        logic [3:0] p;
        p = pos(k);
        pressed[p[3:2]][p[1:0]] = 1'b0;
    endtask

    task automatic release_all();
        for (int r = 0; r < 4; r++) pressed[r] = 4'h0;
    endtask

    task automatic expect_key(input logic [3:0] k);
        exp_dig = {exp_dig[11:0], k};
        q.push_back({k, exp_dig});
    endtask

    task automatic wait_drain(input string name, input int lim);
        int n = 0;
        while ((q.size() != 0 || pend) && n < lim) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (q.size() != 0 || pend) begin
            bad++;
            $display("FAIL %s: got %0d pending strobes want 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic wait_valid(input string name, input logic v, input int lim);
        int n = 0;
        while (kvalid !== v && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(name, {15'h0, kvalid}, {15'h0, v});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_col", {12'h0, col}, 16'h000E);
        chk("rst_key", {12'h0, key}, 16'h0000);
        chk("rst_valid", {15'h0, kvalid}, 16'h0);
        chk("rst_strobe", {15'h0, kstrobe}, 16'h0);
        chk("rst_digit", digit, 16'h0000);
        rst = 1'b0;
        exp_dig = 16'h0;
    endtask

    task automatic tap(input logic [3:0] k);
        expect_key(k);
        press(k);
        wait_drain("tap_drain", 12 * FR);
        release_all();
        wait_valid("tap_release", 1'b0, 6 * FR);
        idle(FR);
    endtask

    initial begin
        int t [5];
        int n;
        rst = 1'b1;
        clr = 1'b0;
        exp_dig = 16'h0;
        release_all();

        // Reset, idle keypad, column stepping
        do_reset();
        idle(3);
        chk("col_hold", {12'h0, col}, 16'h000E);
        idle(1);
        chk("col_step", {12'h0, col}, 16'h000D);
        idle(20 * FR);
        chk("idle_valid", {15'h0, kvalid}, 16'h0);
        chk("idle_digit", digit, 16'h0000);

`ifndef KEYPAD_AUTOREPEAT_EN
        // Single press of '5', long hold, release
        expect_key(4'h5);
        press(4'h5);
        wait_drain("k5_drain", 12 * FR);
        chk("k5_key", {12'h0, key}, 16'h0005);
        chk("k5_valid", {15'h0, kvalid}, 16'h1);
        idle(2);
        chk("k5_digit", digit, 16'h0005);
        idle(20 * FR);
        release_all();
        wait_valid("k5_release", 1'b0, 4 * FR);
        chk("k5_key_hold", {12'h0, key}, 16'h0005);
        idle(FR);

        // Sequence 1..5
        for (int i = 1; i <= 5; i++) tap(4'(i));
        chk("seq_digit", digit, 16'h2345);

        // One-frame bounce of '9'
        press(4'h9);
        idle(FR);
        release_all();
        idle(4 * FR);
        chk("bounce_valid", {15'h0, kvalid}, 16'h0);

        // '0' and 'F' together, then release 'F'
        press(4'h0);
        press(4'hF);
        idle(6 * FR);
        chk("multi_valid", {15'h0, kvalid}, 16'h0);
        chk("multi_digit", digit, 16'h2345);
        expect_key(4'h0);
        unpress(4'hF);
        wait_drain("rollover_drain", 12 * FR);
        chk("rollover_key", {12'h0, key}, 16'h0000);
        release_all();
        wait_valid("rollover_release", 1'b0, 6 * FR);
        idle(FR);

        // Plain clear, then 1234, then clear coincident with 'A'
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        chk("clear_digit", digit, 16'h0000);
        exp_dig = 16'h0;
        for (int i = 1; i <= 4; i++) tap(4'(i));
        chk("pre_a_digit", digit, 16'h1234);
        q.push_back({4'hA, 16'h000A});
        exp_dig = 16'h000A;
        press(4'hA);
        n = 0;
        while (!kstrobe && n < 12 * FR) begin
            @(negedge clk);
            n++;
        end
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        wait_drain("clear_a_drain", 4);
        chk("clear_a_digit", digit, 16'h000A);
        release_all();
        wait_valid("a_release", 1'b0, 6 * FR);
        idle(FR);

        // Mid-frame reset while '3' is held
        expect_key(4'h3);
        press(4'h3);
        wait_drain("k3_drain", 12 * FR);
        idle(FR + 5);
        do_reset();
        expect_key(4'h3);
        wait_drain("k3_rst_drain", 4 * FR);
        idle(2);
        chk("k3_rst_digit", digit, 16'h0003);
        chk("k3_rst_valid", {15'h0, kvalid}, 16'h1);
        release_all();
        wait_valid("k3_release", 1'b0, 6 * FR);
        idle(4 * FR);
`else
        // Auto-repeat: strobes at press, +3, +5, +7, +9 frames
        for (int i = 0; i < 5; i++) expect_key(4'h7);
        press(4'h7);
        for (int i = 0; i < 5; i++) begin
            n = 0;
            while (!kstrobe && n < 12 * FR) begin
                @(negedge clk);
                n++;
            end
            t[i] = cyc;
            @(negedge clk);
        end
        chk("rep_gap1", 16'(t[1] - t[0]), 16'(3 * FR));
        chk("rep_gap2", 16'(t[2] - t[1]), 16'(2 * FR));
        chk("rep_gap3", 16'(t[3] - t[2]), 16'(2 * FR));
        chk("rep_gap4", 16'(t[4] - t[3]), 16'(2 * FR));
        release_all();
        wait_drain("rep_drain", 4);
        wait_valid("rep_release", 1'b0, 6 * FR);
        idle(4 * FR);
        chk("rep_digit", digit, 16'h7777);
`endif
        chk("sb_empty", 16'(q.size()), 16'h0000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
